trace_capture_buffer: RTL and testbench

- Hardware commit-trace capture for the single-cycle CPU (sccomp_dataflow).
- Samples the CPU's pc, inst and register-file write port every clock edge and logs one record each time pc changes, matching the per-instruction pc/instr/regfile log used in simulation.
- Records are buffered in a FIFO and drained over a valid/ready stream to a downstream UART or debug dumper, so trace is available on the board, not only in simulation.

---
 rtl/trace_capture_buffer_if.sv | 20 ++
 rtl/trace_capture_buffer.sv | 119 +++++++++++
 tb/tb_trace_capture_buffer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_buffer_if.sv
// Commit-trace record stream: producer drives valid + record fields, consumer drives ready.
interface trace_capture_buffer_if;
    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_pc;
    logic [31:0] tr_inst;
    logic        tr_wb_en;
    logic [4:0]  tr_wb_addr;
    logic [31:0] tr_wb_data;

    modport master (
        output tr_valid, tr_pc, tr_inst, tr_wb_en, tr_wb_addr, tr_wb_data,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_pc, tr_inst, tr_wb_en, tr_wb_addr, tr_wb_data,
        output tr_ready
    );
endinterface

// File: rtl/trace_capture_buffer.sv
// Logs one {pc, inst, regfile write} record per pc change into a first-word
// fall-through FIFO drained over a valid/ready stream; overflow is counted.
module trace_capture_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] PC_SENTINEL = 32'h44436040,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      cap_en,
    input  logic [31:0]               pc,
    input  logic [31:0]               inst,
    input  logic                      rf_we,
    input  logic [4:0]                rf_waddr,
    input  logic [31:0]               rf_wdata,
    trace_capture_buffer_if.master    tr_io,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic [CNT_W-1:0]          drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LvlOne  = LW'(1);
    localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } rec_t;

    rec_t             storage_q [DEPTH];
    logic [31:0]      pc_pre_q, pc_pre_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic capture, pop, push, is_full, not_empty;
    rec_t wr_rec, head;

    assign not_empty = (level_q != '0);
    assign is_full   = (level_q == LvlFull);
    assign capture   = cap_en && (pc != pc_pre_q);
    assign pop       = not_empty && tr_io.tr_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push      = capture && (!is_full || pop);

    always_comb begin
        wr_rec         = '0;
        wr_rec.pc      = pc;
        wr_rec.inst    = inst;
        wr_rec.wb_en   = rf_we && (rf_waddr != 5'd0);
        wr_rec.wb_addr = rf_waddr;
        wr_rec.wb_data = rf_wdata;
    end

    always_comb begin
        pc_pre_d = pc_pre_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        if (capture) begin
            pc_pre_d = pc;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LvlOne;
        end else if (pop && !push) begin
            level_d = level_q - LvlOne;
        end
        if (capture && !push && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pc_pre_q <= PC_SENTINEL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            pc_pre_q <= pc_pre_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_in) begin
        if (push) begin
            storage_q[wr_ptr_q] <= wr_rec;
        end
    end

    assign head = not_empty ? storage_q[rd_ptr_q] : '0;

    assign tr_io.tr_valid   = not_empty;
    assign tr_io.tr_pc      = head.pc;
    assign tr_io.tr_inst    = head.inst;
    assign tr_io.tr_wb_en   = head.wb_en;
    assign tr_io.tr_wb_addr = head.wb_addr;
    assign tr_io.tr_wb_data = head.wb_data;
    assign level            = level_q;
    assign full             = is_full;
    assign drop_cnt         = drop_q;
endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: vector table plus multi-cycle corner sequences.
module tb_trace_capture_buffer;
    localparam int unsigned DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        cap_en = 1'b0;
    logic [31:0] pc     = '0;
    logic [31:0] inst   = '0;
    logic        rf_we  = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0;
    logic [4:0]  level;
    logic        full;
    logic [15:0] drop_cnt;

    trace_capture_buffer_if tr_if ();

    trace_capture_buffer #(
        .DEPTH       (DEPTH),
        .PC_SENTINEL (32'h44436040),
        .CNT_W       (16)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .cap_en   (cap_en),
        .pc       (pc),
        .inst     (inst),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .tr_io    (tr_if),
        .level    (level),
        .full     (full),
        .drop_cnt (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        cap_en;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_wb_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        int          e_level;
    } vec_t;

    vec_t vt [12];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic drive(input logic ce, input logic [31:0] p, input logic [31:0] in,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rdy);
        cap_en         = ce;
        pc             = p;
        inst           = in;
        rf_we          = we;
        rf_waddr       = wa;
        rf_wdata       = wd;
        tr_if.tr_ready = rdy;
    endtask

    initial begin
        // cap pc inst we addr data rdy | valid pc inst wb addr data level
        vt[0]  = '{1, 32'h00400000, 32'h3c011001, 0, 0, 0, 1,
                   1, 32'h00400000, 32'h3c011001, 0, 0, 0, 1};
        vt[1]  = '{1, 32'h00400004, 32'h34240000, 0, 0, 0, 1,
                   1, 32'h00400004, 32'h34240000, 0, 0, 0, 1};
        vt[2]  = '{1, 32'h00400008, 32'h20050003, 0, 0, 0, 1,
                   1, 32'h00400008, 32'h20050003, 0, 0, 0, 1};
        vt[3]  = '{1, 32'h00400008, 32'h20050003, 0, 0, 0, 1,
                   0, 32'h0, 32'h0, 0, 0, 0, 0};
        for (int i = 4; i < 9; i++) begin
            vt[i] = '{1, 32'h00400010, 32'h00a64020, 1, 8, 5, 0,
                      1, 32'h00400010, 32'h00a64020, 1, 8, 5, 1};
        end
        vt[9]  = '{1, 32'h00400010, 32'h00a64020, 1, 8, 5, 1,
                   0, 32'h0, 32'h0, 0, 0, 0, 0};
        vt[10] = '{1, 32'h00400014, 32'h00004020, 1, 0, 7, 0,
                   1, 32'h00400014, 32'h00004020, 0, 0, 7, 1};
        vt[11] = '{1, 32'h00400014, 32'h00004020, 1, 0, 7, 1,
                   0, 32'h0, 32'h0, 0, 0, 0, 0};

        tr_if.tr_ready = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(tr_if.tr_valid), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_pc", 64'(tr_if.tr_pc), 64'(0));

        // Sequential pcs with a draining consumer, then stall and x0-write records.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].cap_en, vt[i].pc, vt[i].inst, vt[i].rf_we, vt[i].waddr, vt[i].wdata,
                  vt[i].ready);
            tick();
            chk($sformatf("v%0d_valid", i), 64'(tr_if.tr_valid), 64'(vt[i].e_valid));
            chk($sformatf("v%0d_pc", i), 64'(tr_if.tr_pc), 64'(vt[i].e_pc));
            chk($sformatf("v%0d_inst", i), 64'(tr_if.tr_inst), 64'(vt[i].e_inst));
            chk($sformatf("v%0d_wb_en", i), 64'(tr_if.tr_wb_en), 64'(vt[i].e_wb_en));
            chk($sformatf("v%0d_wb_addr", i), 64'(tr_if.tr_wb_addr), 64'(vt[i].e_addr));
            chk($sformatf("v%0d_wb_data", i), 64'(tr_if.tr_wb_data), 64'(vt[i].e_data));
            chk($sformatf("v%0d_level", i), 64'(level), 64'(vt[i].e_level));
        end
        chk("seq_drop", 64'(drop_cnt), 64'(0));

        // Overflow: 20 distinct pcs with consumer stalled.
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h00500000 + 32'(4 * i), 32'h1000 + 32'(i), 0, 0, 0, 0);
            tick();
        end
        chk("ovf_full", 64'(full), 64'(1));
        chk("ovf_level", 64'(level), 64'(16));
        chk("ovf_drop", 64'(drop_cnt), 64'(4));
        chk("ovf_head", 64'(tr_if.tr_pc), 64'(32'h00500000));
        chk("ovf_inst", 64'(tr_if.tr_inst), 64'(32'h1000));

        // Push and pop in the same cycle while full.
        drive(1, 32'h00580000, 32'hcafe0000, 0, 0, 0, 1);
        tick();
        chk("pp_level", 64'(level), 64'(16));
        chk("pp_drop", 64'(drop_cnt), 64'(4));
        chk("pp_full", 64'(full), 64'(1));
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain%0d_pc", i), 64'(tr_if.tr_pc),
                64'(32'h00500000 + 32'(4 * i)));
            tick();
        end
        chk("drain_last_pc", 64'(tr_if.tr_pc), 64'(32'h00580000));
        chk("drain_last_inst", 64'(tr_if.tr_inst), 64'(32'hcafe0000));
        tick();
        chk("drain_level", 64'(level), 64'(0));
        chk("drain_valid", 64'(tr_if.tr_valid), 64'(0));
        chk("drain_drop", 64'(drop_cnt), 64'(4));

        // Capture disabled while pc advances; one record on re-enable.
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h00600000 + 32'(4 * i), 32'h2000 + 32'(i), 0, 0, 0, 0);
            tick();
            chk($sformatf("dis%0d_level", i), 64'(level), 64'(0));
        end
        drive(1, 32'h00600008, 32'h2002, 0, 0, 0, 0);
        tick();
        chk("reen_level", 64'(level), 64'(1));
        chk("reen_pc", 64'(tr_if.tr_pc), 64'(32'h00600008));
        tick();
        chk("reen_once", 64'(level), 64'(1));
        tr_if.tr_ready = 1'b1;
        tick();
        chk("reen_drain", 64'(level), 64'(0));

        // Reset with 7 records buffered while the CPU stalls.
        for (int i = 0; i < 7; i++) begin
            drive(1, 32'h00700000 + 32'(4 * i), 32'h3000 + 32'(i), 0, 0, 0, 0);
            tick();
        end
        tick();
        chk("pre_rst_level", 64'(level), 64'(7));
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(tr_if.tr_valid), 64'(0));
        chk("arst_level", 64'(level), 64'(0));
        chk("arst_drop", 64'(drop_cnt), 64'(0));
        chk("arst_pc", 64'(tr_if.tr_pc), 64'(0));
        tick();
        drive(1, 32'h00400000, 32'h3c011001, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_level", 64'(level), 64'(1));
        chk("post_rst_pc", 64'(tr_if.tr_pc), 64'(32'h00400000));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
